multicycle_control: RTL
=======================

// Module: multicycle_control
// PURPOSE
// - Multi-cycle sequencer for the RV32 datapath: steps each instruction through IF/ID/EX/MEM/WB
//   and drives per-state datapath controls (ALUOp/ALUSrc/RegWrite/memory/PC/IR enables).
// - Replaces combinational opcode decode when the CPU shares one memory port and one ALU
//   across cycles.
// - Sits beside the datapath; ALU_Control still decodes funct fields from ALUOp_o.
// PARAMETERS
// - CNT_W   32   width of retired-instruction counter instr_cnt_o
// PORTS
// - clk_i        in   1      clock, all state updates on posedge
// - rst_i        in   1      asynchronous, active-low reset
// - start_i      in   1      leave IDLE and begin fetching
// - halt_i       in   1      sampled at retire; 1 -> return to IDLE after current instruction
// - Op_i         in   7      opcode field of instruction register (valid from ID onward)
// - zero_i       in   1      ALU zero flag (used in EX of BEQ)
// - mem_ready_i  in   1      memory completes current access this cycle
// - ALUOp_o      out  2      00 I-type funct decode, 10 R-type funct decode, 11 force add, 01 force sub
// - ALUSrc_o     out  1      1 = immediate operand B
// - RegWrite_o   out  1      register file write enable
// - MemtoReg_o   out  1      1 = write-back data from memory
// - MemRead_o    out  1      memory read request
// - MemWrite_o   out  1      memory write request
// - IorD_o       out  1      0 = address from PC, 1 = address from ALU result
// - IRWrite_o    out  1      load instruction register
// - PCWrite_o    out  1      load PC
// - PCSrc_o      out  1      0 = PC+4, 1 = branch target
// - illegal_o    out  1      one-cycle pulse: unsupported opcode dropped in ID
// - busy_o       out  1      1 whenever state != IDLE
// - instr_cnt_o  out  CNT_W  retired-instruction count
// BEHAVIOUR
// - Reset (rst_i=0, async): state=IDLE, op_q=0, instr_cnt_o=0; all control outputs 0.
//   Mid-instruction reset aborts with no further write/PC update.
// - Controls are decoded from state and op_q.
// - Outputs not listed for a state are 0.
// - Legal opcodes:
//   - R      0110011
//   - I-ALU  0010011
//   - LW     0000011
//   - SW     0100011
//   - BEQ    1100011
// - IDLE: start_i=1 -> IF.
// - IF: MemRead_o=1, IorD_o=0. Hold while mem_ready_i=0.
//   On ready: IRWrite_o=1, PCWrite_o=1, PCSrc_o=0, -> ID.
// - ID: op_q<=Op_i.
//   - Legal opcode -> EX.
//   - Illegal: illegal_o=1, -> IF; not counted as retired, halt_i ignored.
// - EX (op_q): R: ALUOp 10 -> WB. I: ALUOp 00, ALUSrc 1 -> WB. LW/SW: ALUOp 11, ALUSrc 1 -> MEM.
//   BEQ: ALUOp 01, PCSrc_o=1, PCWrite_o=zero_i; retire.
// - MEM: IorD_o=1; LW MemRead_o=1, SW MemWrite_o=1. Hold while mem_ready_i=0.
//   On ready: LW -> WB, SW retires.
// - WB: RegWrite_o=1, MemtoReg_o=(op_q==LW); retire.
// - Retire: instr_cnt_o+1 (wraps at 2^CNT_W-1 -> 0); next = halt_i ? IDLE : IF.
// - Request signals stay asserted and stable while waiting; exactly one IRWrite/PCWrite per
//   fetch regardless of wait length.
// - Latency with mem_ready_i tied 1: R/I 4 cycles, LW 5, SW 4, BEQ 3.
// - start_i ignored outside IDLE.
// STRUCTURE
// - Package cpu_ctrl_pkg: state encoding (IDLE..WB, 3 bits), opcode constants, ALUOp codes.
// - Single module. State register + next-state logic + output decode + counter.
// - No sub-module needed.
// TESTING
// - Reset: rst_i=0 mid-MEM of SW -> MemWrite_o=0 immediately, state IDLE, instr_cnt_o=0.
// - R-type with ready=1: Op_i=0110011 -> IF,ID,EX(ALUOp=10),WB(RegWrite=1); count +1 after 4 cycles.
// - LW, mem_ready_i low 3 cycles in IF and 2 in MEM: MemRead held, one IRWrite pulse,
//   IorD=1 in MEM, MemtoReg=1 in WB; 10 cycles total.
// - BEQ: zero_i=1 -> PCWrite=1, PCSrc=1 in EX; zero_i=0 -> PCWrite=0; both count, next state IF.
// - Illegal Op_i=1111111 -> illegal_o pulse in ID, back to IF, count unchanged, no RegWrite/MemWrite.
// - halt_i=1 during WB of addi (0010011) -> IDLE, busy_o=0.
// - Counter wrap with CNT_W=4: 16 retires return instr_cnt_o to 0.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the multi-cycle RV32 control sequencer:
// state encoding, opcode constants and ALUOp codes.
package cpu_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_IF   = 3'd1,
    ST_ID   = 3'd2,
    ST_EX   = 3'd3,
    ST_MEM  = 3'd4,
    ST_WB   = 3'd5
  } state_t;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  localparam logic [1:0] ALU_FUNCT_I = 2'b00;
  localparam logic [1:0] ALU_SUB     = 2'b01;
  localparam logic [1:0] ALU_FUNCT_R = 2'b10;
  localparam logic [1:0] ALU_ADD     = 2'b11;

  function automatic logic op_legal(input logic [6:0] op);
    logic ok;
    case (op)
      OP_R, OP_I, OP_LW, OP_SW, OP_BEQ: ok = 1'b1;
      default:                          ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/multicycle_control.sv
// Multi-cycle IF/ID/EX/MEM/WB sequencer driving datapath controls for a
// shared-memory, shared-ALU RV32 core; also counts retired instructions.
module multicycle_control
  import cpu_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             halt_i,
  input  logic [6:0]       Op_i,
  input  logic             zero_i,
  input  logic             mem_ready_i,
  output logic [1:0]       ALUOp_o,
  output logic             ALUSrc_o,
  output logic             RegWrite_o,
  output logic             MemtoReg_o,
  output logic             MemRead_o,
  output logic             MemWrite_o,
  output logic             IorD_o,
  output logic             IRWrite_o,
  output logic             PCWrite_o,
  output logic             PCSrc_o,
  output logic             illegal_o,
  output logic             busy_o,
  output logic [CNT_W-1:0] instr_cnt_o
);

  state_t             state_r;
  state_t             state_nxt_s;
  logic [6:0]         op_r;
  logic [CNT_W-1:0]   cnt_r;
  logic               retire_s;

  assign instr_cnt_o = cnt_r;

  // State, latched opcode and retired-instruction counter
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_r <= ST_IDLE;
      op_r    <= 7'd0;
      cnt_r   <= '0;
    end else begin
      state_r <= state_nxt_s;
      if (state_r == ST_ID) begin
        op_r <= Op_i;
      end else begin
        op_r <= op_r;
      end
      if (retire_s) begin
        cnt_r <= cnt_r + CNT_W'(1);
      end else begin
        cnt_r <= cnt_r;
      end
    end
  end

  // Next-state and control decode from current state and latched opcode
  always_comb begin
    state_nxt_s = state_r;
    retire_s    = 1'b0;
    ALUOp_o     = ALU_FUNCT_I;
    ALUSrc_o    = 1'b0;
    RegWrite_o  = 1'b0;
    MemtoReg_o  = 1'b0;
    MemRead_o   = 1'b0;
    MemWrite_o  = 1'b0;
    IorD_o      = 1'b0;
    IRWrite_o   = 1'b0;
    PCWrite_o   = 1'b0;
    PCSrc_o     = 1'b0;
    illegal_o   = 1'b0;
    busy_o      = (state_r != ST_IDLE);

    case (state_r)
      ST_IDLE: begin
        if (start_i) begin
          state_nxt_s = ST_IF;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end

      // Request held until ready; IR/PC load only on the completing cycle
      ST_IF: begin
        MemRead_o = 1'b1;
        if (mem_ready_i) begin
          IRWrite_o   = 1'b1;
          PCWrite_o   = 1'b1;
          state_nxt_s = ST_ID;
        end else begin
          state_nxt_s = ST_IF;
        end
      end

      ST_ID: begin
        if (op_legal(Op_i)) begin
          state_nxt_s = ST_EX;
        end else begin
          illegal_o   = 1'b1;
          state_nxt_s = ST_IF;
        end
      end

      ST_EX: begin
        case (op_r)
          OP_R: begin
            ALUOp_o     = ALU_FUNCT_R;
            state_nxt_s = ST_WB;
          end
          OP_I: begin
            ALUOp_o     = ALU_FUNCT_I;
            ALUSrc_o    = 1'b1;
            state_nxt_s = ST_WB;
          end
          OP_LW, OP_SW: begin
            ALUOp_o     = ALU_ADD;
            ALUSrc_o    = 1'b1;
            state_nxt_s = ST_MEM;
          end
          OP_BEQ: begin
            ALUOp_o     = ALU_SUB;
            PCSrc_o     = 1'b1;
            PCWrite_o   = zero_i;
            retire_s    = 1'b1;
            state_nxt_s = halt_i ? ST_IDLE : ST_IF;
          end
          default: begin
            state_nxt_s = ST_IF;
          end
        endcase
      end

      ST_MEM: begin
        IorD_o     = 1'b1;
        MemRead_o  = (op_r == OP_LW);
        MemWrite_o = (op_r == OP_SW);
        if (!mem_ready_i) begin
          state_nxt_s = ST_MEM;
        end else if (op_r == OP_LW) begin
          state_nxt_s = ST_WB;
        end else begin
          retire_s    = 1'b1;
          state_nxt_s = halt_i ? ST_IDLE : ST_IF;
        end
      end

      ST_WB: begin
        RegWrite_o  = 1'b1;
        MemtoReg_o  = (op_r == OP_LW);
        retire_s    = 1'b1;
        state_nxt_s = halt_i ? ST_IDLE : ST_IF;
      end

      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

endmodule
